// File: rtl/alu2_slice_scheduler.sv
// Time-shares one external 2-bit ALU slice between two requesters.
// Each op runs LSB-first, two bits per cycle, with the carry chained between slices.
module alu2_slice_scheduler #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req0_mode,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,
   input  logic             req1_mode,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_cout,
   output logic             rsp_id,
   output logic             busy,
   output logic [1:0]       alu_a,
   output logic [1:0]       alu_b,
   output logic [3:0]       alu_op,
   output logic             alu_mode,
   output logic             alu_cin,
   input  logic [1:0]       alu_res,
   input  logic             alu_cout,
   output logic [1:0]       state_dbg
);

   localparam int NS = WIDTH / 2;
   localparam int KW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [KW-1:0] KMAX = KW'(NS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic             last_grant;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] r_q;
   logic [3:0]       op_q;
   logic             mode_q;
   logic             id_q;
   logic             carry_q;
   logic [KW-1:0]    k;

   logic             grant_any;
   logic             grant_id;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [3:0]       sel_op;
   logic             sel_mode;
   logic             sel_cin;

   // Round robin only matters on a tie; a lone requester always wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      sel_a     = grant_id ? req1_a    : req0_a;
      sel_b     = grant_id ? req1_b    : req0_b;
      sel_op    = grant_id ? req1_op   : req0_op;
      sel_mode  = grant_id ? req1_mode : req0_mode;
      sel_cin   = grant_id ? req1_cin  : req0_cin;
   end

   // Readies are masked during reset so nothing looks accepted while the FSM is held.
   assign req0_ready = rst_n && (state == IDLE) && grant_any && !grant_id;
   assign req1_ready = rst_n && (state == IDLE) && grant_any &&  grant_id;

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_op   = '0;
      alu_mode = 1'b0;
      alu_cin  = 1'b0;
      if (state == RUN) begin
         alu_a    = a_q[{k, 1'b0} +: 2];
         alu_b    = b_q[{k, 1'b0} +: 2];
         alu_op   = op_q;
         alu_mode = mode_q;
         alu_cin  = carry_q;
      end
   end

   assign rsp_valid = (state == DONE);
   assign rsp_data  = (state == DONE) ? r_q : '0;
   assign rsp_cout  = (state == DONE) ? carry_q : 1'b0;
   assign rsp_id    = (state == DONE) ? id_q : 1'b0;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         op_q       <= '0;
         mode_q     <= 1'b0;
         id_q       <= 1'b0;
         carry_q    <= 1'b0;
         k          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  a_q        <= sel_a;
                  b_q        <= sel_b;
                  op_q       <= sel_op;
                  mode_q     <= sel_mode;
                  id_q       <= grant_id;
                  carry_q    <= sel_cin;
                  r_q        <= '0;
                  k          <= '0;
                  last_grant <= grant_id;
                  state      <= RUN;
               end
            end
            RUN: begin
               r_q[{k, 1'b0} +: 2] <= alu_res;
               carry_q             <= alu_cout;
               // k parks on the last slice instead of wrapping.
               if (k == KMAX) state <= DONE;
               else           k     <= k + 1'b1;
            end
            DONE: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu2_slice_scheduler.sv
// Bench for alu2_slice_scheduler: directed scenarios plus randomized traffic,
// checked against an arithmetic reference model and a response queue.
module tb_alu2_slice_scheduler;

   localparam int W  = 8;
   localparam int NS = W / 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]   req0_op, req1_op;
   logic         req0_mode, req1_mode, req0_cin, req1_cin;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_cout, rsp_id, busy;
   logic [1:0]   alu_a, alu_b, alu_res;
   logic [3:0]   alu_op;
   logic         alu_mode, alu_cin, alu_cout;
   logic [1:0]   state_dbg;

   int           total = 0;
   int           bad = 0;
   logic [W+1:0] exp_q[$];
   int           id_log[$];
   int           rsp_cnt = 0;
   int           grant_cnt = 0;
   logic         last_id = 1'b1;

   // clock / reset
   always #5 clk = ~clk;

   alu2_slice_scheduler #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_op(req0_op), .req0_mode(req0_mode), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_op(req1_op), .req1_mode(req1_mode), .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
      .alu_cin(alu_cin), .alu_res(alu_res), .alu_cout(alu_cout), .state_dbg(state_dbg)
   );

   // slice stub: plain 2-bit adder
   assign {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {2'b00, alu_cin};

   // reference model: the whole op is just a W-bit add with carry in
   function automatic logic [W+1:0] model(logic id, logic [W-1:0] a, logic [W-1:0] b, logic cin);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      return {s[W], s[W-1:0], id};
   endfunction

   // carry into bit 2k of a full-width add
   function automatic logic slice_cin(logic [W-1:0] a, logic [W-1:0] b, logic cin, int k);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      return s[2*k] ^ a[2*k] ^ b[2*k];
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard / protocol monitor
   always @(negedge clk) begin
      logic         g;
      logic [W+1:0] e;
      if (rst_n) begin
         check("busy_vs_outstanding", busy, exp_q.size() != 0);
         check("ready_exclusive", req0_ready && req1_ready, 0);
         check("ready0_needs_valid", req0_ready && !req0_valid, 0);
         check("ready1_needs_valid", req1_ready && !req1_valid, 0);
         if (rsp_valid) check("rsp_without_op", exp_q.size(), 1);
         if (req0_ready || req1_ready) begin
            check("grant_while_outstanding", exp_q.size(), 0);
            g = req1_ready;
            if (req0_valid && req1_valid) check("round_robin", g, !last_id);
            last_id = g;
            exp_q.push_back(g ? model(1'b1, req1_a, req1_b, req1_cin)
                              : model(1'b0, req0_a, req0_b, req0_cin));
            grant_cnt++;
         end
         if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e[W:1]);
            check("rsp_cout", rsp_cout, e[W+1]);
            check("rsp_id", rsp_id, e[0]);
            id_log.push_back(int'(rsp_id));
            rsp_cnt++;
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int id, logic v, logic [W-1:0] a, logic [W-1:0] b,
                          logic [3:0] op, logic mode, logic cin);
      if (id == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_mode = mode; req0_cin = cin;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_mode = mode; req1_cin = cin;
      end
   endtask

   task automatic issue(int id, logic [W-1:0] a, logic [W-1:0] b,
                        logic [3:0] op, logic mode, logic cin);
      int n;
      n = 0;
      set_req(id, 1'b1, a, b, op, mode, cin);
      #1;
      while (!(id == 0 ? req0_ready : req1_ready) && n < 50) begin
         step();
         n++;
      end
      check("accept_timeout", n < 50, 1);
      step();
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   task automatic run_slices(logic [W-1:0] a, logic [W-1:0] b,
                             logic [3:0] op, logic mode, logic cin);
      logic [W-1:0] sa, sb;
      for (int k = 0; k < NS; k++) begin
         sa = a >> (2 * k);
         sb = b >> (2 * k);
         check("alu_a", alu_a, sa[1:0]);
         check("alu_b", alu_b, sb[1:0]);
         check("alu_cin", alu_cin, slice_cin(a, b, cin, k));
         check("alu_op", alu_op, op);
         check("alu_mode", alu_mode, mode);
         check("rsp_valid_early", rsp_valid, 0);
         step();
      end
      check("latency_rsp_valid", rsp_valid, 1);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      last_id = 1'b1;
   endtask

   initial begin
      logic [W-1:0] ra, rb, rc, rd;
      logic [3:0]   rop;
      logic         acc0, acc1;
      int           base, n;

      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rop;
      logic         rm, rci, acc0, acc1;
      int           base, gbase, n;

      apply_reset();
      set_req(0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      set_req(1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      rsp_ready = 1'b0;
      #1;
      check("reset_outputs",
            {req0_ready, req1_ready, rsp_valid, rsp_data, rsp_cout, rsp_id, busy,
             alu_a, alu_b, alu_op, alu_mode, alu_cin}, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // 1: basic add, slice walk and latency
      rsp_ready = 1'b1;
      issue(0, 8'hB7, 8'h5C, 4'h9, 1'b1, 1'b0);
      run_slices(8'hB7, 8'h5C, 4'h9, 1'b1, 1'b0);
      check("t1_data", rsp_data, 8'h13);
      check("t1_cout", rsp_cout, 1);
      check("t1_id", rsp_id, 0);
      step();
      check("t1_idle", busy, 0);

      // 2: carry ripples through every slice
      issue(0, 8'hFF, 8'h00, 4'h3, 1'b0, 1'b1);
      run_slices(8'hFF, 8'h00, 4'h3, 1'b0, 1'b1);
      check("t2_data", rsp_data, 8'h00);
      check("t2_cout", rsp_cout, 1);
      step();

      // 4: response back-pressure
      rsp_ready = 1'b0;
      ra = W'($urandom); rb = W'($urandom); rop = 4'($urandom);
      issue(1, ra, rb, rop, 1'b1, 1'b1);
      run_slices(ra, rb, rop, 1'b1, 1'b1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_ready0", req0_ready, 0);
         check("t4_ready1", req1_ready, 0);
         check("t4_valid", rsp_valid, 1);
         check("t4_data", rsp_data, model(1'b1, ra, rb, 1'b1) >> 1);
         check("t4_id", rsp_id, 1);
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      check("t4_idle", busy, 0);
      check("t4_rsp_gone", rsp_valid, 0);

      // 5: reset in the middle of an op
      base = rsp_cnt;
      issue(0, 8'hFF, 8'hFF, 4'h5, 1'b1, 1'b0);
      step();
      step();
      check("t5_pre_alu_a", alu_a, 2'b11);
      set_req(1, 1'b1, 8'h21, 8'h43, 4'h6, 1'b0, 1'b1);
      apply_reset();
      #1;
      check("t5_outputs_zero",
            {req0_ready, req1_ready, rsp_valid, rsp_data, rsp_cout, rsp_id, busy,
             alu_a, alu_b, alu_op, alu_mode, alu_cin}, 0);
      step();
      step();
      check("t5_no_rsp", rsp_cnt, base);
      req1_valid = 1'b0;
      rst_n = 1'b1;
      step();
      issue(1, 8'h21, 8'h43, 4'h6, 1'b0, 1'b1);
      run_slices(8'h21, 8'h43, 4'h6, 1'b0, 1'b1);
      check("t5_id", rsp_id, 1);
      check("t5_data", rsp_data, 8'h65);
      step();
      check("t5_one_rsp", rsp_cnt, base + 1);

      // 6: short req1 pulse while busy is never granted
      base = rsp_cnt;
      gbase = grant_cnt;
      issue(0, 8'h0F, 8'h01, 4'h1, 1'b0, 1'b0);
      step();
      set_req(1, 1'b1, 8'hAA, 8'h55, 4'h2, 1'b1, 1'b0);
      #1;
      check("t6_ready1", req1_ready, 0);
      step();
      req1_valid = 1'b0;
      step();
      step();
      check("t6_done", rsp_valid, 1);
      check("t6_data", rsp_data, 8'h10);
      step();
      for (int i = 0; i < 3; i++) begin
         check("t6_idle", busy, 0);
         step();
      end
      check("t6_rsp_count", rsp_cnt, base + 1);
      check("t6_grant_count", grant_cnt, gbase + 1);

      // 3: both requesters valid from reset alternate
      set_req(0, 1'b1, W'($urandom), W'($urandom), 4'($urandom), 1'b0, 1'($urandom));
      set_req(1, 1'b1, W'($urandom), W'($urandom), 4'($urandom), 1'b1, 1'($urandom));
      apply_reset();
      step();
      rst_n = 1'b1;
      base = rsp_cnt;
      n = 0;
      while (rsp_cnt < base + 4 && n < 200) begin
         step();
         n++;
      end
      check("t3_timeout", n < 200, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      check("t3_idle", busy, 0);
      if (id_log.size() >= base + 4) begin
         check("t3_id0", id_log[base], 0);
         check("t3_id1", id_log[base + 1], 1);
         check("t3_id2", id_log[base + 2], 0);
         check("t3_id3", id_log[base + 3], 1);
      end else begin
         check("t3_id_log_size", id_log.size(), base + 4);
      end

      // randomized traffic with random back-pressure
      for (int i = 0; i < 600; i++) begin
         if (!req0_valid && $urandom_range(0, 2) == 0)
            set_req(0, 1'b1, W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         if (!req1_valid && $urandom_range(0, 2) == 0)
            set_req(1, 1'b1, W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         acc0 = req0_valid && req0_ready;
         acc1 = req1_valid && req1_ready;
         step();
         if (acc0) req0_valid = 1'b0;
         if (acc1) req1_valid = 1'b0;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      check("drain_timeout", n < 50, 1);
      step();
      check("drain_queue_empty", exp_q.size(), 0);
      check("random_traffic_seen", rsp_cnt > 20, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
